// File: rtl/vector_range_pkg.sv
// Shared definitions for the vector range guard: mode bit positions,
// per-lane compare result, and default sizing.
package vector_range_pkg;

  localparam int MODE_INCL_BIT  = 0;  // 1 = inclusive bounds, 0 = exclusive
  localparam int MODE_CLAMP_BIT = 1;  // 1 = clamp out-of-range, 0 = zero it

  localparam int DEF_N     = 12;
  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic below;
    logic above;
    logic ok;
  } lane_res_t;

endpackage

// File: rtl/range_cmp_lane.sv
// One element of the range guard. The compare half works on the raw input
// element, so its result is ready to be registered with the data in S1.
// The select half works on the S1-registered element and result and feeds S2.
module range_cmp_lane
  import vector_range_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] lower,
  input  logic [W-1:0] upper,
  input  logic         incl,
  output lane_res_t    res,
  input  logic [W-1:0] s_x,
  input  logic [W-1:0] s_lower,
  input  logic [W-1:0] s_upper,
  input  lane_res_t    s_res,
  input  logic         s_clamp,
  input  logic         s_bnd_err,
  output logic [W-1:0] sel
);

  // Unsigned window compare; below/above classify a failing element so the
  // clamp path knows which bound to substitute.
  always_comb begin
    res    = '0;
    res.ok = incl ? ((x >= lower) && (x <= upper))
                  : ((x >  lower) && (x <  upper));
    res.below = !res.ok && (incl ? (x < lower) : (x <= lower));
    res.above = !res.ok && !res.below;
  end

  // Output select; inverted bounds force zero regardless of mode.
  always_comb begin
    sel = '0;
    if (s_bnd_err)     sel = '0;
    else if (s_res.ok) sel = s_x;
    else if (s_clamp)  sel = s_res.below ? s_lower : s_upper;
    else               sel = '0;
  end

endmodule

// File: rtl/vector_range_guard.sv
// Streaming range checker: two-stage valid/ready pipeline (S1 = data plus
// compare results, S2 = sanitised output) with saturating error statistics.
module vector_range_guard
  import vector_range_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   in_vec,
  input  logic [W-1:0]     lower_bnd,
  input  logic [W-1:0]     upper_bnd,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_vec,
  output logic [N-1:0]     out_err,
  output logic             out_bnd_err,
  output logic [CNT_W-1:0] err_count,
  output logic             sticky_err,
  input  logic             clear_sticky
);

  lane_res_t [N-1:0] cmp_res;
  logic [N*W-1:0]    sel_vec;

  logic              s1_valid_q, s1_valid_d;
  logic [N*W-1:0]    s1_vec_q, s1_vec_d;
  logic [W-1:0]      s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d;
  logic              s1_clamp_q, s1_clamp_d, s1_bnd_q, s1_bnd_d;
  lane_res_t [N-1:0] s1_res_q, s1_res_d;

  logic              s2_valid_q, s2_valid_d;
  logic [N*W-1:0]    out_vec_q, out_vec_d;
  logic [N-1:0]      out_err_q, out_err_d;
  logic              out_bnd_q, out_bnd_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;

  logic              s2_adv, in_hs, out_hs;
  logic [N-1:0]      s1_err;

  for (genvar g = 0; g < N; g++) begin : g_lane
    range_cmp_lane #(.W(W)) u_lane (
      .x         (in_vec[g*W +: W]),
      .lower     (lower_bnd),
      .upper     (upper_bnd),
      .incl      (mode[MODE_INCL_BIT]),
      .res       (cmp_res[g]),
      .s_x       (s1_vec_q[g*W +: W]),
      .s_lower   (s1_lo_q),
      .s_upper   (s1_hi_q),
      .s_res     (s1_res_q[g]),
      .s_clamp   (s1_clamp_q),
      .s_bnd_err (s1_bnd_q),
      .sel       (sel_vec[g*W +: W])
    );
    assign s1_err[g] = !s1_res_q[g].ok || s1_bnd_q;
  end

  // Handshake, pipeline advance and statistics next-state.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    in_hs    = in_valid && in_ready;
    out_hs   = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_vec_d   = s1_vec_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    s1_clamp_d = s1_clamp_q;
    s1_bnd_d   = s1_bnd_q;
    s1_res_d   = s1_res_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_hs) begin
      s1_vec_d   = in_vec;
      s1_lo_d    = lower_bnd;
      s1_hi_d    = upper_bnd;
      s1_clamp_d = mode[MODE_CLAMP_BIT];
      s1_bnd_d   = lower_bnd > upper_bnd;
      s1_res_d   = cmp_res;
    end

    s2_valid_d = s2_valid_q;
    out_vec_d  = out_vec_q;
    out_err_d  = out_err_q;
    out_bnd_d  = out_bnd_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_vec_d = sel_vec;
        out_err_d = s1_err;
        out_bnd_d = s1_bnd_q;
      end
    end

    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (out_hs && (|out_err_q)) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      sticky_d = 1'b1;                  // set beats a simultaneous clear
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; reset empties the pipeline and clears statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s1_clamp_q <= 1'b0;
      s1_bnd_q   <= 1'b0;
      s1_res_q   <= '0;
      s2_valid_q <= 1'b0;
      out_vec_q  <= '0;
      out_err_q  <= '0;
      out_bnd_q  <= 1'b0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_vec_q   <= s1_vec_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      s1_clamp_q <= s1_clamp_d;
      s1_bnd_q   <= s1_bnd_d;
      s1_res_q   <= s1_res_d;
      s2_valid_q <= s2_valid_d;
      out_vec_q  <= out_vec_d;
      out_err_q  <= out_err_d;
      out_bnd_q  <= out_bnd_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_vec     = out_vec_q;
  assign out_err     = out_err_q;
  assign out_bnd_err = out_bnd_q;
  assign err_count   = cnt_q;
  assign sticky_err  = sticky_q;

endmodule
